layer_decoder: RTL and testbench
================================

# layer_decoder

Downstream stage of a neuron layer: converts the layer's per-neuron output bitstreams back to binary by counting ones over a fixed window of enabled cycles. At each window end it snapshots all counts, scans them sequentially for the winning neuron (argmax), and presents counts plus class on a valid/ready interface to the control or readout logic. Counting is continuous: a new window starts immediately while the previous result is scanned and presented.

## Interface
- `NEURON_COUNT`, default 2: number of bitstreams, one per neuron of the upstream layer.
- `WINDOW`, default 256: bitstream length in enabled cycles; must be ≥ 2.
- `COUNT_WIDTH`, default $clog2(WINDOW+1): width of each count; holds the value WINDOW.
- `clk`  in  1  clock; all state updates on the rising edge.
- `n_rst`  in  1  reset; synchronous, active-low.
- `layer_output`  in  NEURON_COUNT  one bit per neuron per cycle, driven by the upstream layer.
- `stream_enable`  in  1  the current `layer_output` bit is part of the stream.
- `result_count`  out  NEURON_COUNT × COUNT_WIDTH (unpacked array)  snapshot ones-count per neuron.
- `result_class`  out  $clog2(NEURON_COUNT), minimum 1  argmax neuron index.
- `result_valid`  out  1  result is held and stable.
- `result_ready`  in  1  consumer accepts the result.
- `overrun`  out  1  sticky flag: a window finished while the previous result was still pending.

## Operation
- Accumulators: one COUNT_WIDTH count per neuron, plus a window position counter 0..WINDOW-1.
- `stream_enable` low: no accumulator or position change.
- Enabled cycle, position < WINDOW-1: acc[i] += layer_output[i]; position += 1.
- Enabled cycle, position = WINDOW-1 (window end):
  - position wraps to 0 and all accumulators clear to 0.
  - The completed totals acc[i] + layer_output[i] go to the snapshot only if the output FSM is IDLE; otherwise they are discarded and `overrun` is set.
- Output FSM states: IDLE, SCAN, PRESENT.
  - IDLE → SCAN on a window end that loads the snapshot. Set best_idx = 0, best_val = snap[0], scan_idx = 1.
  - SCAN compares one neuron per cycle. Replace best only if snap[scan_idx] > best_val (strict), so ties go to the lowest index. After index NEURON_COUNT-1: SCAN → PRESENT, with `result_class` ← best_idx.
  - NEURON_COUNT = 1: SCAN lasts one cycle and the class is 0.
  - In PRESENT, `result_valid` = 1. When `result_ready` is 1, go to IDLE at that edge.
  - `result_count` and `result_class` stay stable throughout PRESENT.
- `overrun` clears only on reset.
- Reset (`n_rst` low at an edge), including mid-window or mid-SCAN/PRESENT:
  - accumulators, position, snapshot, `result_count` all 0;
  - `result_class` 0, `result_valid` 0, `overrun` 0;
  - state IDLE. Any partial window is lost.

## Timing
- Let edge E be the one that captures the last bit of a window (state IDLE at E).
  - SCAN occupies the cycles after edges E .. E+NEURON_COUNT-1.
  - `result_valid` rises after edge E+NEURON_COUNT.
  - Latency from last bit to valid: NEURON_COUNT cycles.
- Handshake: transfer occurs on an edge where `result_valid` and `result_ready` are both 1. `result_valid` falls after that edge. `result_ready` is ignored outside PRESENT.
- Window end on the same edge as acceptance (state PRESENT at that edge): the window is dropped and `overrun` is set, because the check uses the pre-edge state.
- With `stream_enable` held high, results never overrun as long as `result_ready` is asserted within WINDOW − NEURON_COUNT − 1 cycles of valid.

## Structure
- Shared package `bitstream_pkg` holds:
  - the `decoder_state_t` enum (IDLE, SCAN, PRESENT);
  - the count-width helper function, used by both the encoder and the decoder.
- Sub-module `bitstream_counter` (one per neuron via a generate loop): takes `enable`, `bit_in`, and `window_end`; exposes the running total and the final total. The window position counter and the output FSM stay in `layer_decoder`.

## Test plan
- NEURON_COUNT=2, WINDOW=8, enable high. Neuron 0 all ones, neuron 1 alternating 1,0. Result: counts {8,4}, class 0. Valid asserted 2 cycles after the 8th bit.
- NEURON_COUNT=3, WINDOW=8, counts {3,5,5}: class 1, confirming the strict-greater tie-break. All zeros: counts {0,0,0}, class 0.
- `stream_enable` low for 5 cycles mid-window, with ones on the bus during those cycles: counts unchanged, and valid delayed by exactly 5 cycles.
- `result_ready` held low for longer than one window: second window dropped, `overrun`=1, first result still held. Then ready high: accepted, valid drops, and the third window is captured normally.
- Reset asserted mid-SCAN and mid-window: all outputs 0 at the next edge. A fresh full window after reset yields a correct result with no contamination from before the reset.
- WINDOW=4, back-to-back windows with ready always high: every window produces exactly one transfer and `overrun` stays 0.

Source files
------------

// File: rtl/bitstream_pkg.sv
// Shared types and width helpers for the bitstream encoder/decoder blocks.
// Pure declarations: no latency, no flow control.
package bitstream_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        PRESENT = 2'd2
    } decoder_state_t;

    // Width that can hold every count 0..window inclusive.
    function automatic int count_width(input int window);
        return $clog2(window + 1);
    endfunction

    // Class index width, never narrower than one bit.
    function automatic int class_width(input int neurons);
        return (neurons > 1) ? $clog2(neurons) : 1;
    endfunction

endpackage

// File: rtl/bitstream_counter.sv
// Ones-counter for one bitstream; the final total includes the current bit, and the count restarts on window end.
// Registered accumulator; the final total is combinational; no backpressure (enable only).
module bitstream_counter #(
    parameter int COUNT_WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   enable,
    input  logic                   bit_in,
    input  logic                   window_end,
    output logic [COUNT_WIDTH-1:0] running_total,
    output logic [COUNT_WIDTH-1:0] final_total
);

    logic [COUNT_WIDTH-1:0] acc_q;
    logic [COUNT_WIDTH-1:0] acc_d;

    assign final_total   = acc_q + COUNT_WIDTH'(bit_in);
    assign running_total = acc_q;

    always_comb begin
        acc_d = acc_q;
        if (enable) begin
            acc_d = window_end ? '0 : final_total;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/layer_decoder.sv
// Turns per-neuron bitstreams into counts and an argmax class per window; valid NEURON_COUNT cycles after the last bit.
// Result is held until result_ready; a window ending while a result is pending is dropped and sets sticky overrun.
module layer_decoder
    import bitstream_pkg::*;
#(
    parameter int NEURON_COUNT = 2,
    parameter int WINDOW       = 256,
    parameter int COUNT_WIDTH  = count_width(WINDOW)
) (
    input  logic                                   clk,
    input  logic                                   n_rst,
    input  logic [NEURON_COUNT-1:0]                layer_output,
    input  logic                                   stream_enable,
    output logic [COUNT_WIDTH-1:0]                 result_count [NEURON_COUNT],
    output logic [class_width(NEURON_COUNT)-1:0]   result_class,
    output logic                                   result_valid,
    input  logic                                   result_ready,
    output logic                                   overrun
);

    localparam int POS_W   = $clog2(WINDOW);
    localparam int SCAN_W  = $clog2(NEURON_COUNT + 1);
    localparam int CLASS_W = class_width(NEURON_COUNT);

    typedef logic [COUNT_WIDTH-1:0] count_t;

    decoder_state_t     state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    count_t             snap_q [NEURON_COUNT];
    count_t             snap_d [NEURON_COUNT];
    count_t             final_total [NEURON_COUNT];
    count_t             running_total_unused [NEURON_COUNT];
    logic [CLASS_W-1:0] best_idx_q, best_idx_d;
    count_t             best_val_q, best_val_d;
    logic [SCAN_W-1:0]  scan_idx_q, scan_idx_d;
    logic [CLASS_W-1:0] class_q, class_d;
    logic               overrun_q, overrun_d;
    count_t             cand_val;
    logic               window_end;

    assign window_end = stream_enable && (pos_q == POS_W'(WINDOW - 1));

    for (genvar gi = 0; gi < NEURON_COUNT; gi++) begin : g_cnt
        bitstream_counter #(
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_cnt (
            .clk           (clk),
            .n_rst         (n_rst),
            .enable        (stream_enable),
            .bit_in        (layer_output[gi]),
            .window_end    (window_end),
            .running_total (running_total_unused[gi]),
            .final_total   (final_total[gi])
        );
    end

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        snap_d     = snap_q;
        best_idx_d = best_idx_q;
        best_val_d = best_val_q;
        scan_idx_d = scan_idx_q;
        class_d    = class_q;
        overrun_d  = overrun_q;
        cand_val   = '0;

        if (stream_enable) begin
            pos_d = window_end ? '0 : pos_q + 1'b1;
        end
        // The pending check uses the pre-edge state, so a window ending on the acceptance edge is lost.
        if (window_end && state_q != IDLE) begin
            overrun_d = 1'b1;
        end

        for (int i = 0; i < NEURON_COUNT; i++) begin
            if (scan_idx_q == SCAN_W'(i)) begin
                cand_val = snap_q[i];
            end
        end

        case (state_q)
            IDLE: begin
                if (window_end) begin
                    snap_d     = final_total;
                    best_idx_d = '0;
                    best_val_d = final_total[0];
                    scan_idx_d = SCAN_W'(1);
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                // Strict compare keeps the lowest index on ties.
                if (scan_idx_q == SCAN_W'(NEURON_COUNT)) begin
                    class_d = best_idx_q;
                    state_d = PRESENT;
                end else begin
                    if (cand_val > best_val_q) begin
                        best_val_d = cand_val;
                        best_idx_d = CLASS_W'(scan_idx_q);
                    end
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            PRESENT: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            pos_q      <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
            scan_idx_q <= '0;
            class_q    <= '0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < NEURON_COUNT; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
            scan_idx_q <= scan_idx_d;
            class_q    <= class_d;
            overrun_q  <= overrun_d;
            snap_q     <= snap_d;
        end
    end

    assign result_count = snap_q;
    assign result_class = class_q;
    assign result_valid = (state_q == PRESENT);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_layer_decoder.sv
// Directed bench for layer_decoder: three instances (2x8, 3x8, 2x4) exercising counting, argmax, gaps, overrun, reset.
module tb_layer_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance a: NEURON_COUNT=2, WINDOW=8
    logic       a_rst, a_en, a_rdy, a_vld, a_ovr, a_cls;
    logic [1:0] a_out;
    logic [3:0] a_cnt [2];

    // Instance b: NEURON_COUNT=3, WINDOW=8
    logic       b_rst, b_en, b_rdy, b_vld, b_ovr;
    logic [2:0] b_out;
    logic [1:0] b_cls;
    logic [3:0] b_cnt [3];

    // Instance c: NEURON_COUNT=2, WINDOW=4
    logic       c_rst, c_en, c_rdy, c_vld, c_ovr, c_cls;
    logic [1:0] c_out;
    logic [2:0] c_cnt [2];

    layer_decoder #(.NEURON_COUNT(2), .WINDOW(8)) u_a (
        .clk(clk), .n_rst(a_rst), .layer_output(a_out), .stream_enable(a_en),
        .result_count(a_cnt), .result_class(a_cls), .result_valid(a_vld),
        .result_ready(a_rdy), .overrun(a_ovr)
    );

    layer_decoder #(.NEURON_COUNT(3), .WINDOW(8)) u_b (
        .clk(clk), .n_rst(b_rst), .layer_output(b_out), .stream_enable(b_en),
        .result_count(b_cnt), .result_class(b_cls), .result_valid(b_vld),
        .result_ready(b_rdy), .overrun(b_ovr)
    );

    layer_decoder #(.NEURON_COUNT(2), .WINDOW(4)) u_c (
        .clk(clk), .n_rst(c_rst), .layer_output(c_out), .stream_enable(c_en),
        .result_count(c_cnt), .result_class(c_cls), .result_valid(c_vld),
        .result_ready(c_rdy), .overrun(c_ovr)
    );

    typedef struct {
        logic [7:0] s0, s1, s2;
        int         c0, c1, c2;
        int         cls;
    } vec_t;

    typedef struct {
        logic [3:0] s0, s1;
        int         c0, c1, cls;
    } cvec_t;

    vec_t  tbl  [4];
    cvec_t ctbl [5];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_window(input logic [7:0] s0, input logic [7:0] s1,
                            input int gap_at, input int gap_len);
        for (int c = 0; c < 8; c++) begin
            if (c == gap_at) begin
                a_en  = 1'b0;
                a_out = 2'b11;
                repeat (gap_len) step();
            end
            a_en  = 1'b1;
            a_out = {s1[c], s0[c]};
            step();
        end
        a_en  = 1'b0;
        a_out = 2'b00;
    endtask

    task automatic a_expect(input string tag, input int c0, input int c1, input int cls);
        int lat;
        lat = 0;
        while (!a_vld && lat < 10) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, lat, 2);
        chk({tag, "_cnt0"}, a_cnt[0], c0);
        chk({tag, "_cnt1"}, a_cnt[1], c1);
        chk({tag, "_class"}, a_cls, cls);
    endtask

    task automatic a_accept(input string tag);
        a_rdy = 1'b1;
        step();
        a_rdy = 1'b0;
        chk({tag, "_valid_after_accept"}, a_vld, 0);
    endtask

    initial begin
        int nres;

        tbl[0] = '{s0: 8'h07, s1: 8'h1F, s2: 8'hF8, c0: 3, c1: 5, c2: 5, cls: 1};
        tbl[1] = '{s0: 8'h00, s1: 8'h00, s2: 8'h00, c0: 0, c1: 0, c2: 0, cls: 0};
        tbl[2] = '{s0: 8'h01, s1: 8'h0F, s2: 8'h3F, c0: 1, c1: 4, c2: 6, cls: 2};
        tbl[3] = '{s0: 8'h7F, s1: 8'hFE, s2: 8'hEF, c0: 7, c1: 7, c2: 7, cls: 0};

        ctbl[0] = '{s0: 4'hF, s1: 4'h0, c0: 4, c1: 0, cls: 0};
        ctbl[1] = '{s0: 4'h1, s1: 4'h7, c0: 1, c1: 3, cls: 1};
        ctbl[2] = '{s0: 4'h0, s1: 4'h0, c0: 0, c1: 0, cls: 0};
        ctbl[3] = '{s0: 4'h3, s1: 4'hF, c0: 2, c1: 4, cls: 1};
        ctbl[4] = '{s0: 4'hF, s1: 4'hF, c0: 4, c1: 4, cls: 0};

        a_rst = 0; a_en = 0; a_rdy = 0; a_out = '0;
        b_rst = 0; b_en = 0; b_rdy = 0; b_out = '0;
        c_rst = 0; c_en = 0; c_rdy = 1; c_out = '0;
        repeat (2) step();

        chk("rst_valid", a_vld, 0);
        chk("rst_overrun", a_ovr, 0);
        chk("rst_class", a_cls, 0);
        chk("rst_cnt0", a_cnt[0], 0);
        chk("rst_cnt1", a_cnt[1], 0);
        a_rst = 1; b_rst = 1; c_rst = 1;
        step();

        // Basic window: neuron0 all ones, neuron1 alternating starting with 1.
        a_window(8'hFF, 8'h55, -1, 0);
        chk("basic_scan_valid", a_vld, 0);
        a_expect("basic", 8, 4, 0);
        a_accept("basic");

        // Five disabled cycles with ones on the bus must not count.
        a_window(8'h03, 8'h70, 3, 5);
        a_expect("gap", 2, 3, 1);
        a_accept("gap");

        // Hold ready low across a whole second window.
        a_window(8'hFF, 8'h00, -1, 0);
        a_expect("ovr_first", 8, 0, 0);
        a_window(8'h00, 8'hFF, -1, 0);
        chk("ovr_flag", a_ovr, 1);
        chk("ovr_held_valid", a_vld, 1);
        chk("ovr_held_cnt0", a_cnt[0], 8);
        chk("ovr_held_cnt1", a_cnt[1], 0);
        chk("ovr_held_class", a_cls, 0);
        a_accept("ovr");
        a_window(8'h01, 8'h03, -1, 0);
        a_expect("third", 1, 2, 1);
        chk("ovr_sticky", a_ovr, 1);
        a_accept("third");

        // Reset in the middle of SCAN.
        a_window(8'hFF, 8'hFF, -1, 0);
        a_rst = 0;
        step();
        chk("rst_scan_valid", a_vld, 0);
        chk("rst_scan_cnt0", a_cnt[0], 0);
        chk("rst_scan_cnt1", a_cnt[1], 0);
        chk("rst_scan_class", a_cls, 0);
        chk("rst_scan_overrun", a_ovr, 0);
        a_rst = 1;
        repeat (3) step();
        chk("rst_scan_stays_idle", a_vld, 0);

        // Reset in the middle of a window, then a clean window.
        a_en = 1; a_out = 2'b11;
        repeat (5) step();
        a_en = 0; a_out = 2'b00; a_rst = 0;
        step();
        a_rst = 1;
        a_window(8'h00, 8'h07, -1, 0);
        a_expect("post_rst", 0, 3, 1);
        a_accept("post_rst");

        // Table-driven argmax checks on the three-neuron instance.
        for (int v = 0; v < 4; v++) begin
            for (int c = 0; c < 8; c++) begin
                b_en  = 1'b1;
                b_out = {tbl[v].s2[c], tbl[v].s1[c], tbl[v].s0[c]};
                step();
            end
            b_en = 1'b0; b_out = '0;
            step();
            step();
            chk($sformatf("tbl%0d_valid_early", v), b_vld, 0);
            step();
            chk($sformatf("tbl%0d_valid", v), b_vld, 1);
            chk($sformatf("tbl%0d_cnt0", v), b_cnt[0], tbl[v].c0);
            chk($sformatf("tbl%0d_cnt1", v), b_cnt[1], tbl[v].c1);
            chk($sformatf("tbl%0d_cnt2", v), b_cnt[2], tbl[v].c2);
            chk($sformatf("tbl%0d_class", v), b_cls, tbl[v].cls);
            b_rdy = 1'b1;
            step();
            b_rdy = 1'b0;
            chk($sformatf("tbl%0d_accept", v), b_vld, 0);
        end
        chk("tbl_overrun", b_ovr, 0);

        // Back-to-back short windows with ready always high.
        nres = 0;
        for (int t = 0; t < 26; t++) begin
            if (t < 20) begin
                c_en  = 1'b1;
                c_out = {ctbl[t / 4].s1[t % 4], ctbl[t / 4].s0[t % 4]};
            end else begin
                c_en  = 1'b0;
                c_out = 2'b00;
            end
            step();
            if (c_vld) begin
                if (nres < 5) begin
                    chk($sformatf("b2b%0d_cnt0", nres), c_cnt[0], ctbl[nres].c0);
                    chk($sformatf("b2b%0d_cnt1", nres), c_cnt[1], ctbl[nres].c1);
                    chk($sformatf("b2b%0d_class", nres), c_cls, ctbl[nres].cls);
                end
                nres++;
            end
        end
        chk("b2b_transfers", nres, 5);
        chk("b2b_overrun", c_ovr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
